button_bank: RTL

//   N-channel push-button conditioner: synchronises raw inputs, applies

---
 rtl/button_bank.sv | 126 ++++++++++++
 1 files changed

// File: rtl/button_bank.sv
// N-channel push-button conditioner: 2-flop synchroniser, counter debounce, press/release pulses.
// Optional auto-repeat of press while held is enabled by defining BUTTON_BANK_REPEAT_EN.
module button_bank #(
    parameter int N_BTN      = 5,
    parameter int DB_CYCLES  = 16,
    parameter int REP_DELAY  = 500,
    parameter int REP_PERIOD = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] raw,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] rel,
    output logic             any_press
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    // Elaboration-time sanity check on the configuration.
    if (N_BTN < 1 || DB_CYCLES < 1 || REP_DELAY < 1 || REP_PERIOD < 1) begin : g_param_check
        $error("button_bank: all parameters must be >= 1");
    end

    logic [N_BTN-1:0] s1;
    logic [N_BTN-1:0] s2;
    logic [CW-1:0]    cnt [N_BTN];
    logic [N_BTN-1:0] flip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // A channel flips on the edge where its disagreement has lasted DB_CYCLES samples.
    always_comb begin
        flip = '0;
        for (int i = 0; i < N_BTN; i++) begin
            flip[i] = (s2[i] != level[i]) && (cnt[i] == DB_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (s2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (flip[i]) begin
                    level[i] <= s2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef BUTTON_BANK_REPEAT_EN
    localparam int RMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REP_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REP_PERIOD - 1);

    logic [RW-1:0]    rc [N_BTN];
    logic [N_BTN-1:0] rep_armed;
    logic [N_BTN-1:0] rep_fire;

    // rep_armed selects between the initial delay and the steady repeat period.
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < N_BTN; i++) begin
            rep_fire[i] = level[i] && !flip[i] &&
                          (rc[i] == (rep_armed[i] ? PERIOD_LAST : DELAY_LAST));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press     <= '0;
            rel       <= '0;
            rep_armed <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                rc[i] <= '0;
            end
        end else begin
            press <= (flip & s2) | rep_fire;
            rel   <= flip & ~s2;
            for (int i = 0; i < N_BTN; i++) begin
                if (!level[i] || flip[i]) begin
                    rc[i]        <= '0;
                    rep_armed[i] <= 1'b0;
                end else if (rep_fire[i]) begin
                    rc[i]        <= '0;
                    rep_armed[i] <= 1'b1;
                end else begin
                    rc[i] <= rc[i] + 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press <= '0;
            rel   <= '0;
        end else begin
            press <= flip & s2;
            rel   <= flip & ~s2;
        end
    end
`endif

    assign any_press = |press;

endmodule
